// File: rtl/gfx_pkg.sv
// Shared definitions for the draw_* pixel pipeline blocks.
// Canvas dimensions are deliberately kept out of here; each block takes them as parameters.
package gfx_pkg;

    localparam int CORDW = 16;

    typedef logic signed [CORDW-1:0] coord_t;

    // Signed bounds test; coordinates arrive sign-extended to 32 bits.
    function automatic logic in_canvas(input logic signed [31:0] px_x,
                                       input logic signed [31:0] px_y,
                                       input int w,
                                       input int h);
        return (px_x >= 0) && (px_x < w) && (px_y >= 0) && (px_y < h);
    endfunction

endpackage

// File: rtl/draw_fb_write_if.sv
// Pixel input bus (drawer -> writer) and framebuffer write bus (writer -> memory).
// Handshakes: drawer pixel transfers when drawing=1 and oe=1 in the same cycle;
// a framebuffer write transfers when fb_we=1 and fb_ready=1, and fb_addr/fb_colr hold while stalled.
interface draw_px_if #(
    parameter int CORDW = gfx_pkg::CORDW,
    parameter int COLRW = 4
);
    logic                    drawing;
    logic signed [CORDW-1:0] x;
    logic signed [CORDW-1:0] y;
    logic [COLRW-1:0]        colr;
    logic                    oe;

    modport master (output drawing, x, y, colr, input oe);
    modport slave  (input drawing, x, y, colr, output oe);
endinterface

interface fb_wr_if #(
    parameter int ADDRW = 16,
    parameter int COLRW = 4
);
    logic             fb_we;
    logic [ADDRW-1:0] fb_addr;
    logic [COLRW-1:0] fb_colr;
    logic             fb_ready;

    modport master (output fb_we, fb_addr, fb_colr, input fb_ready);
    modport slave  (input fb_we, fb_addr, fb_colr, output fb_ready);
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered head (no fall-through) and occupancy count.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    always_comb begin
        push_ok  = push && (count_q != (PW+1)'(DEPTH));
        pop_ok   = pop && (count_q != '0);
        // Power-of-two depth lets the pointers wrap by plain overflow.
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/draw_fb_write.sv
// Pixel writer: register, clip, compute linear address, then queue writes to the framebuffer.
// oe reserves a queue slot for every pixel in flight, so the two pipeline stages never stall.
module draw_fb_write #(
    parameter int CORDW  = gfx_pkg::CORDW,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 180,
    parameter int ADDRW  = 16,
    parameter int COLRW  = 4,
    parameter int DEPTH  = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    draw_px_if.slave  px,
    fb_wr_if.master   fb,
    output logic      clipped,
    output logic      busy
);
    import gfx_pkg::*;

    localparam int CNTW = $clog2(DEPTH) + 1;
    localparam int QW   = ADDRW + COLRW;

    logic                    s1_v_q, s1_v_d;
    logic                    s2_v_q, s2_v_d;
    logic                    clipped_q, clipped_d;
    logic signed [CORDW-1:0] x1_q, x1_d;
    logic signed [CORDW-1:0] y1_q, y1_d;
    logic [COLRW-1:0]        c1_q, c1_d;
    logic [ADDRW-1:0]        a2_q, a2_d;
    logic [COLRW-1:0]        c2_q, c2_d;

    logic            accept;
    logic            s1_in;
    logic            pop;
    logic            fifo_empty;
    logic [CNTW-1:0] count;
    logic [CNTW:0]   inflight;
    logic [QW-1:0]   head;

    always_comb begin
        inflight  = (CNTW+1)'(count) + (CNTW+1)'(s1_v_q) + (CNTW+1)'(s2_v_q);
        // Gated by rst_n so the drawer sees oe=0 for the whole reset.
        px.oe     = rst_n && (inflight < (CNTW+1)'(DEPTH));
        accept    = px.drawing && px.oe;

        s1_v_d    = accept;
        x1_d      = px.x;
        y1_d      = px.y;
        c1_d      = px.colr;

        s1_in     = in_canvas(32'(x1_q), 32'(y1_q), WIDTH, HEIGHT);
        s2_v_d    = s1_v_q && s1_in;
        clipped_d = s1_v_q && !s1_in;
        a2_d      = ADDRW'(32'(y1_q) * 32'(WIDTH) + 32'(x1_q));
        c2_d      = c1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s2_v_q    <= 1'b0;
            clipped_q <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s2_v_q    <= s2_v_d;
            clipped_q <= clipped_d;
        end
    end

    always_ff @(posedge clk) begin
        x1_q <= x1_d;
        y1_q <= y1_d;
        c1_q <= c1_d;
        a2_q <= a2_d;
        c2_q <= c2_d;
    end

    fifo_sync #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (s2_v_q),
        .wdata ({a2_q, c2_q}),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .count (count)
    );

    assign fb.fb_we   = !fifo_empty;
    assign fb.fb_addr = head[QW-1:COLRW];
    assign fb.fb_colr = head[COLRW-1:0];
    assign pop        = fb.fb_we && fb.fb_ready;
    assign clipped    = clipped_q;
    assign busy       = s1_v_q || s2_v_q || !fifo_empty;

endmodule

// File: tb/tb_draw_fb_write.sv
// Directed bench for draw_fb_write: latency, clipping, backpressure, full-rate streaming, reset.
module tb_draw_fb_write;

    localparam int CORDW  = 16;
    localparam int WIDTH  = 320;
    localparam int HEIGHT = 180;
    localparam int ADDRW  = 16;
    localparam int COLRW  = 4;
    localparam int DEPTH  = 4;
    localparam int W      = ADDRW + COLRW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clipped;
    logic busy;

    draw_px_if #(.CORDW(CORDW), .COLRW(COLRW)) px ();
    fb_wr_if   #(.ADDRW(ADDRW), .COLRW(COLRW)) fb ();

    draw_fb_write #(
        .CORDW(CORDW), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .ADDRW(ADDRW), .COLRW(COLRW), .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .px      (px),
        .fb      (fb),
        .clipped (clipped),
        .busy    (busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // scoreboard state
    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    int wr_cnt = 0;
    int clip_cnt = 0;
    int outstanding = 0;
    bit chk_occ = 1'b0;
    logic [ADDRW-1:0] last_addr = '0;

    int tab_x[$];
    int tab_y[$];
    int tab_c[$];
    int idx = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_px(input int xx, input int yy, input int cc);
        tab_x.push_back(xx);
        tab_y.push_back(yy);
        tab_c.push_back(cc);
    endtask

    task automatic clear_tab();
        tab_x.delete();
        tab_y.delete();
        tab_c.delete();
        idx = 0;
    endtask

    // driver: present table pixels, advancing on each accepted handshake
    task automatic feed(input int budget, output int iters);
        iters = 0;
        while (idx < tab_x.size() && iters < budget) begin
            px.drawing = 1'b1;
            px.x       = CORDW'(tab_x[idx]);
            px.y       = CORDW'(tab_y[idx]);
            px.colr    = COLRW'(tab_c[idx]);
            @(negedge clk);
            if (px.oe) begin
                outstanding++;
                if (tab_x[idx] >= 0 && tab_x[idx] < WIDTH && tab_y[idx] >= 0 && tab_y[idx] < HEIGHT)
                    exp_q.push_back({ADDRW'(tab_y[idx] * WIDTH + tab_x[idx]), COLRW'(tab_c[idx])});
                idx++;
            end
            iters++;
            step();
        end
        px.drawing = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk("drain_busy", busy, 0);
        repeat (3) step();
    endtask

    // monitor: every write must match the head of the expected queue
    always @(negedge clk) begin
        if (fb.fb_we && fb.fb_ready) begin
            wr_cnt++;
            last_addr = fb.fb_addr;
            outstanding--;
            chk("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
                chk("write_order", 32'({fb.fb_addr, fb.fb_colr}), 32'(exp_q.pop_front()));
        end
        if (clipped) begin
            clip_cnt++;
            outstanding--;
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_occ) chk("occupancy_le_depth", 32'(outstanding <= DEPTH), 1);
    end

    initial begin
        int it;
        int wr_base;
        int clip_base;

        px.drawing  = 1'b0;
        px.x        = '0;
        px.y        = '0;
        px.colr     = '0;
        fb.fb_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_oe", px.oe, 0);
        chk("rst_fb_we", fb.fb_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clipped", clipped, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_oe", px.oe, 1);
        chk("post_rst_fb_we", fb.fb_we, 0);

        // single pixel (5,2,7): write at N+3, idle at N+4
        step();
        wr_base = wr_cnt;
        clear_tab();
        load_px(5, 2, 7);
        feed(4, it);
        @(negedge clk);
        chk("single_n1_we", fb.fb_we, 0);
        step();
        @(negedge clk);
        chk("single_n2_we", fb.fb_we, 0);
        step();
        @(negedge clk);
        chk("single_n3_we", fb.fb_we, 1);
        chk("single_n3_addr", fb.fb_addr, 645);
        chk("single_n3_colr", fb.fb_colr, 7);
        chk("single_n3_busy", busy, 1);
        step();
        @(negedge clk);
        chk("single_n4_busy", busy, 0);
        chk("single_n4_we", fb.fb_we, 0);
        step();
        chk("single_writes", wr_cnt - wr_base, 1);

        // clipping: three discarded, corner pixel written
        wr_base   = wr_cnt;
        clip_base = clip_cnt;
        clear_tab();
        load_px(-1, 0, 1);
        load_px(320, 0, 2);
        load_px(0, 180, 3);
        load_px(319, 179, 12);
        feed(20, it);
        chk("clip_accepted", idx, 4);
        wait_idle(30);
        chk("clip_pulses", clip_cnt - clip_base, 3);
        chk("clip_writes", wr_cnt - wr_base, 1);
        chk("clip_corner_addr", last_addr, 57599);
        chk("clip_queue_empty", exp_q.size(), 0);
        outstanding = 0;

        // backpressure: 10-pixel line with fb_ready low
        chk_occ     = 1'b1;
        fb.fb_ready = 1'b0;
        wr_base     = wr_cnt;
        clear_tab();
        for (int i = 0; i < 10; i++) load_px(10 + i, 3, i);
        feed(12, it);
        @(negedge clk);
        chk("bp_oe_low", px.oe, 0);
        chk("bp_accepted", idx, 4);
        chk("bp_no_writes", wr_cnt - wr_base, 0);
        chk("bp_we_held", fb.fb_we, 1);
        chk("bp_head_addr", fb.fb_addr, 970);
        repeat (3) step();
        @(negedge clk);
        chk("bp_head_stable", fb.fb_addr, 970);
        chk("bp_colr_stable", fb.fb_colr, 0);
        step();
        fb.fb_ready = 1'b1;
        feed(60, it);
        chk("bp_all_accepted", idx, 10);
        wait_idle(30);
        chk("bp_writes", wr_cnt - wr_base, 10);
        chk("bp_queue_empty", exp_q.size(), 0);

        // full queue then continuous streaming with fb_ready high
        fb.fb_ready = 1'b0;
        wr_base     = wr_cnt;
        clear_tab();
        for (int i = 0; i < 24; i++) load_px(i, 100, i % 16);
        feed(8, it);
        chk("stream_fill", idx, 4);
        fb.fb_ready = 1'b1;
        feed(100, it);
        chk("stream_rate_cycles", it, 21);
        wait_idle(30);
        chk("stream_writes", wr_cnt - wr_base, 24);
        chk("stream_last_addr", last_addr, 32023);
        chk_occ = 1'b0;

        // reset with three queued writes
        fb.fb_ready = 1'b0;
        clear_tab();
        for (int i = 0; i < 3; i++) load_px(i, 0, 5);
        feed(6, it);
        repeat (4) step();
        @(negedge clk);
        chk("mid_queued_we", fb.fb_we, 1);
        chk("mid_queued_busy", busy, 1);
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", fb.fb_we, 0);
        chk("mid_rst_oe", px.oe, 0);
        chk("mid_rst_busy", busy, 0);
        exp_q.delete();
        outstanding = 0;
        fb.fb_ready = 1'b1;
        wr_base     = wr_cnt;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_release_oe", px.oe, 1);
        chk("mid_release_we", fb.fb_we, 0);
        repeat (6) step();
        chk("mid_no_stale_writes", wr_cnt - wr_base, 0);
        clear_tab();
        load_px(1, 1, 9);
        feed(4, it);
        wait_idle(20);
        chk("mid_new_write", wr_cnt - wr_base, 1);
        chk("mid_new_addr", last_addr, 321);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
